// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer controller.
// Imported by the prescaler, the interface and the top.
package timer_pkg;

    localparam int WIDTH_DEF   = 64;
    localparam int PRESC_W_DEF = 8;

    typedef enum logic [1:0] {
        T_IDLE,
        T_RUN,
        T_DONE
    } timer_state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between the timer register file
// and the timer controller.
interface timer_ctrl_if
    import timer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PRESC_W = PRESC_W_DEF
);

    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   load_val;
    logic [WIDTH-1:0]   cmp_val;
    logic [PRESC_W-1:0] presc;
    logic               dir_up;
    logic               periodic;
    logic               irq_ack;
    logic [WIDTH-1:0]   count;
    logic               busy;
    logic               irq;

    modport master (
        output start, stop, load_val, cmp_val, presc,
        output dir_up, periodic, irq_ack,
        input  count, busy, irq
    );

    modport slave (
        input  start, stop, load_val, cmp_val, presc,
        input  dir_up, periodic, irq_ack,
        output count, busy, irq
    );

endinterface

// File: rtl/timer_presc.sv
// Clock prescaler: one tick every (presc+1) enabled cycles.
// Counter is parked at zero while disabled.
module timer_presc
    import timer_pkg::*;
#(
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    localparam logic [PRESC_W-1:0] ONE = PRESC_W'(1);

    logic [PRESC_W-1:0] presc_cnt;

    assign tick = en && (presc_cnt == presc);

    // divide counter: wraps on tick, cleared when not running
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
        end else if (!en || tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + ONE;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Timer sequencer: config latch, prescaled up/down counter,
// compare against target, sticky irq, one-shot or periodic.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    timer_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    timer_state_t       state;
    timer_state_t       state_nx;

    logic [WIDTH-1:0]   count_q;
    logic [WIDTH-1:0]   load_q;
    logic [WIDTH-1:0]   cmp_q;
    logic [PRESC_W-1:0] presc_q;
    logic               dir_q;
    logic               periodic_q;
    logic               irq_q;

    logic               running;
    logic               tick;
    logic               start_ok;
    logic               advance;
    logic               match;

    assign running  = (state == T_RUN);
    // stop has priority over start; start is ignored while running
    assign start_ok = bus.start && !bus.stop && !running;
    assign advance  = running && !bus.stop && tick;
    assign match    = advance && (count_q == cmp_q);

    timer_presc #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .presc (presc_q),
        .tick  (tick)
    );

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= T_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            T_IDLE: begin
                if (start_ok) state_nx = T_RUN;
            end
            T_RUN: begin
                if (bus.stop) begin
                    state_nx = T_IDLE;
                end else if (match && !periodic_q) begin
                    state_nx = T_DONE;
                end
            end
            T_DONE: begin
                if (bus.stop) begin
                    state_nx = T_IDLE;
                end else if (start_ok) begin
                    state_nx = T_RUN;
                end
            end
            default: state_nx = T_IDLE;
        endcase
    end

    // configuration latched once per start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_q     <= '0;
            cmp_q      <= '0;
            presc_q    <= '0;
            dir_q      <= 1'b0;
            periodic_q <= 1'b0;
        end else if (start_ok) begin
            load_q     <= bus.load_val;
            cmp_q      <= bus.cmp_val;
            presc_q    <= bus.presc;
            dir_q      <= bus.dir_up;
            periodic_q <= bus.periodic;
        end
    end

    // counter: load on start, reload or hold on match, else step
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (start_ok) begin
            count_q <= bus.load_val;
        end else if (match) begin
            if (periodic_q) count_q <= load_q;
        end else if (advance) begin
            count_q <= dir_q ? count_q + ONE : count_q - ONE;
        end
    end

    // sticky irq; a fresh match beats a coincident ack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (match) begin
            irq_q <= 1'b1;
        end else if (bus.irq_ack) begin
            irq_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.busy  = running;
    assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Scenario bench for timer_ctrl: each step pushes its pulses
// and expected outputs, then is popped and compared per cycle.
module tb_timer_ctrl;
    import timer_pkg::*;

    localparam int W  = 64;
    localparam int PW = 8;
    localparam logic [W-1:0] ONES = '1;

    typedef struct {
        logic         start;
        logic         stop;
        logic         ack;
        logic [W-1:0] count;
        logic         busy;
        logic         irq;
    } step_t;

    step_t sb[$];
    int    checks = 0;
    int    errors = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    timer_ctrl_if #(.WIDTH(W), .PRESC_W(PW)) bus ();

    timer_ctrl #(.WIDTH(W), .PRESC_W(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic push(input logic s, input logic st, input logic a,
                        input logic [W-1:0] c, input logic b,
                        input logic i);
        step_t e;
        e.start = s;
        e.stop  = st;
        e.ack   = a;
        e.count = c;
        e.busy  = b;
        e.irq   = i;
        sb.push_back(e);
    endtask

    task automatic cfg(input logic [W-1:0] ld, input logic [W-1:0] cm,
                       input logic [PW-1:0] ps, input logic up,
                       input logic per);
        bus.load_val = ld;
        bus.cmp_val  = cm;
        bus.presc    = ps;
        bus.dir_up   = up;
        bus.periodic = per;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irq_ack = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.irq_ack = 1'b0;
        cfg('0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset: count=%0h busy=%b irq=%b want 0 0 0",
                     bus.count, bus.busy, bus.irq);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: count=%0h busy=%b irq=%b want 0 0 0",
                     bus.count, bus.busy, bus.irq);
        end
    endtask

    task automatic test_oneshot_up();
        step_t e;
        do_reset();
        cfg(64'd0, 64'd3, 8'd0, 1'b1, 1'b0);
        push(1, 0, 0, 64'd0, 1, 0);
        push(0, 0, 0, 64'd1, 1, 0);
        push(0, 0, 0, 64'd2, 1, 0);
        push(0, 0, 0, 64'd3, 1, 0);
        push(0, 0, 0, 64'd3, 0, 1);
        push(0, 0, 0, 64'd3, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL oneshot_up: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
    endtask

    task automatic test_presc_down();
        step_t e;
        do_reset();
        cfg(64'd10, 64'd8, 8'd2, 1'b0, 1'b0);
        push(1, 0, 0, 64'd10, 1, 0);
        push(0, 0, 0, 64'd10, 1, 0);
        push(0, 0, 0, 64'd10, 1, 0);
        push(0, 0, 0, 64'd9, 1, 0);
        push(0, 0, 0, 64'd9, 1, 0);
        push(0, 0, 0, 64'd9, 1, 0);
        push(0, 0, 0, 64'd8, 1, 0);
        push(0, 0, 0, 64'd8, 1, 0);
        push(0, 0, 0, 64'd8, 1, 0);
        push(0, 0, 0, 64'd8, 0, 1);
        push(0, 0, 0, 64'd8, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL presc_down: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
    endtask

    task automatic test_periodic();
        step_t e;
        do_reset();
        cfg(64'd5, 64'd7, 8'd0, 1'b1, 1'b1);
        push(1, 0, 0, 64'd5, 1, 0);
        push(0, 0, 0, 64'd6, 1, 0);
        push(0, 0, 0, 64'd7, 1, 0);
        push(0, 0, 0, 64'd5, 1, 1);
        push(0, 0, 0, 64'd6, 1, 1);
        push(0, 0, 1, 64'd7, 1, 0);
        push(0, 0, 0, 64'd5, 1, 1);
        push(0, 0, 0, 64'd6, 1, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL periodic: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
    endtask

    task automatic test_wrap();
        step_t e;
        do_reset();
        cfg(64'd0, ONES - 64'd1, 8'd0, 1'b0, 1'b0);
        push(1, 0, 0, 64'd0, 1, 0);
        push(0, 0, 0, ONES, 1, 0);
        push(0, 0, 0, ONES - 64'd1, 1, 0);
        push(0, 0, 0, ONES - 64'd1, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL wrap_down: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
        do_reset();
        cfg(ONES, 64'd1, 8'd0, 1'b1, 1'b0);
        push(1, 0, 0, ONES, 1, 0);
        push(0, 0, 0, 64'd0, 1, 0);
        push(0, 0, 0, 64'd1, 1, 0);
        push(0, 0, 0, 64'd1, 0, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL wrap_up: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
    endtask

    task automatic test_stop();
        step_t e;
        do_reset();
        cfg(64'd0, 64'd100, 8'd0, 1'b1, 1'b0);
        push(1, 0, 0, 64'd0, 1, 0);
        push(0, 0, 0, 64'd1, 1, 0);
        push(0, 0, 0, 64'd2, 1, 0);
        push(1, 0, 0, 64'd3, 1, 0);
        push(0, 0, 0, 64'd4, 1, 0);
        push(0, 1, 0, 64'd4, 0, 0);
        push(0, 0, 0, 64'd4, 0, 0);
        push(1, 1, 0, 64'd4, 0, 0);
        push(0, 0, 0, 64'd4, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL stop: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
    endtask

    task automatic test_async_reset_ack();
        step_t e;
        do_reset();
        cfg(64'd0, 64'd1, 8'd0, 1'b1, 1'b1);
        push(1, 0, 0, 64'd0, 1, 0);
        push(0, 0, 0, 64'd1, 1, 0);
        push(0, 0, 0, 64'd0, 1, 1);
        push(0, 0, 0, 64'd1, 1, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL pre_reset: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== '0 || bus.busy !== 1'b0 || bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0h busy=%b irq=%b want 0 0 0",
                     bus.count, bus.busy, bus.irq);
        end
        @(negedge clk);
        reset = 1'b0;
        cfg(64'd5, 64'd7, 8'd0, 1'b1, 1'b1);
        push(1, 0, 0, 64'd5, 1, 0);
        push(0, 0, 0, 64'd6, 1, 0);
        push(0, 0, 0, 64'd7, 1, 0);
        push(0, 0, 1, 64'd5, 1, 1);
        push(0, 0, 1, 64'd6, 1, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.start   = e.start;
            bus.stop    = e.stop;
            bus.irq_ack = e.ack;
            @(negedge clk);
            checks++;
            if (bus.count !== e.count || bus.busy !== e.busy ||
                bus.irq !== e.irq) begin
                errors++;
                $display("FAIL ack_vs_match: got %0h/%b/%b want %0h/%b/%b",
                         bus.count, bus.busy, bus.irq,
                         e.count, e.busy, e.irq);
            end
        end
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_oneshot_up();
        test_presc_down();
        test_periodic();
        test_wrap();
        test_stop();
        test_async_reset_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
